// File: rtl/cpu_thread_sched_if.sv
// rtl/cpu_thread_sched_if.sv - scheduler control/status bundle shared by execution, pipeline and job loader
interface cpu_thread_sched_if #(
    parameter int N_THREADS     = 4,
    parameter int N_THREADS_MSB = 1,
    parameter int IADDR_WIDTH   = 7
);
    logic [N_THREADS-1:0]   thread_ready;
    logic                   switch_req;
    logic [IADDR_WIDTH-1:0] save_ip;
    logic                   thread_almost_switched;
    logic                   ip_wr_en;
    logic [N_THREADS_MSB:0] ip_wr_thread;
    logic [IADDR_WIDTH-1:0] ip_wr_data;
    logic                   invalidate;
    logic                   reload;
    logic [N_THREADS_MSB:0] thread_num;
    logic [IADDR_WIDTH-1:0] thread_ip;
    logic                   idle;

    modport master (
        output thread_ready, switch_req, save_ip, thread_almost_switched,
               ip_wr_en, ip_wr_thread, ip_wr_data,
        input  invalidate, reload, thread_num, thread_ip, idle
    );

    modport slave (
        input  thread_ready, switch_req, save_ip, thread_almost_switched,
               ip_wr_en, ip_wr_thread, ip_wr_data,
        output invalidate, reload, thread_num, thread_ip, idle
    );
endinterface

// File: rtl/cpu_thread_sched.sv
// rtl/cpu_thread_sched.sv - round-robin hardware thread scheduler with per-thread resume IP table
module cpu_thread_sched #(
    parameter int N_THREADS     = 4,
    parameter int N_THREADS_MSB = 1,
    parameter int IADDR_WIDTH   = 7
) (
    input  logic              CLK,
    input  logic              reset,
    cpu_thread_sched_if.slave bus
);
    localparam int THR_W = N_THREADS_MSB + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_invalidate;
    logic                   r_reload;
    logic [THR_W-1:0]       r_thread_num;
    logic [IADDR_WIDTH-1:0] r_thread_ip;
    logic                   r_idle;
    logic [IADDR_WIDTH-1:0] r_ip_table [N_THREADS];

    state_t                 w_state_nxt;
    logic                   w_invalidate_nxt;
    logic                   w_reload_nxt;
    logic [THR_W-1:0]       w_thread_num_nxt;
    logic [IADDR_WIDTH-1:0] w_thread_ip_nxt;
    logic                   w_idle_nxt;
    logic                   w_save_en;
    logic                   w_found;
    logic [THR_W-1:0]       w_sel;

    // Descending scan so the nearest ready thread after thread_num wins; offset N wraps to thread_num itself.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_thread_num;
        for (int i = N_THREADS; i >= 1; i--) begin
            if (bus.thread_ready[r_thread_num + THR_W'(i)]) begin
                w_found = 1'b1;
                w_sel   = r_thread_num + THR_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_invalidate_nxt = 1'b0;
        w_reload_nxt     = 1'b0;
        w_thread_num_nxt = r_thread_num;
        w_thread_ip_nxt  = r_thread_ip;
        w_idle_nxt       = r_idle;
        w_save_en        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt      = S_SETTLE;
                    w_thread_num_nxt = w_sel;
                    // A job load landing on the thread being picked must not be missed.
                    if (bus.ip_wr_en && (bus.ip_wr_thread == w_sel)) begin
                        w_thread_ip_nxt = bus.ip_wr_data;
                    end else begin
                        w_thread_ip_nxt = r_ip_table[w_sel];
                    end
                    w_reload_nxt = 1'b1;
                    w_idle_nxt   = 1'b0;
                end
            end
            S_SETTLE: begin
                if (bus.thread_almost_switched) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.switch_req) begin
                    w_state_nxt      = S_IDLE;
                    w_save_en        = 1'b1;
                    w_invalidate_nxt = 1'b1;
                    w_idle_nxt       = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idle_nxt  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_invalidate <= 1'b1;
            r_reload     <= 1'b0;
            r_thread_num <= THR_W'(N_THREADS - 1);
            r_thread_ip  <= '0;
            r_idle       <= 1'b1;
            for (int i = 0; i < N_THREADS; i++) begin
                r_ip_table[i] <= '0;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_invalidate <= w_invalidate_nxt;
            r_reload     <= w_reload_nxt;
            r_thread_num <= w_thread_num_nxt;
            r_thread_ip  <= w_thread_ip_nxt;
            r_idle       <= w_idle_nxt;
            if (bus.ip_wr_en) begin
                r_ip_table[bus.ip_wr_thread] <= bus.ip_wr_data;
            end
            // Later assignment lets the yielding thread's save win over a same-entry job load.
            if (w_save_en) begin
                r_ip_table[r_thread_num] <= bus.save_ip;
            end
        end
    end

    assign bus.invalidate = r_invalidate;
    assign bus.reload     = r_reload;
    assign bus.thread_num = r_thread_num;
    assign bus.thread_ip  = r_thread_ip;
    assign bus.idle       = r_idle;
endmodule
